// File: rtl/mc_pkg.sv
// Shared multi-cycle CPU definitions: FSM state codes, opcode constants and the
// control-field encodings used by the controller, datapath and ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StImmEx  = 4'd10,
    StImmWb  = 4'd11,
    StJump   = 4'd12,
    StJal    = 4'd13,
    StHalt   = 4'd14
  } state_e;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // alu_op
  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;

  // pc_src
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // reg_dst
  localparam logic [1:0] DstRt = 2'b00;
  localparam logic [1:0] DstRd = 2'b01;
  localparam logic [1:0] DstRa = 2'b10;

  // mem_to_reg
  localparam logic [1:0] WbAluOut = 2'b00;
  localparam logic [1:0] WbMdr    = 2'b01;
  localparam logic [1:0] WbPc     = 2'b10;

  // alu_src_b
  localparam logic [1:0] SrcbReg   = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbBrOff = 2'b11;

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM. Registered state, outputs decoded from state;
// the memory strobes in FETCH follow mem_ready combinationally.
// Ports:
//   clk, rst_n (sync, active-low)  clock and reset
//   opcode, zero, mem_ready        instruction opcode, ALU zero flag, memory done
//   state                          current state code
//   iord .. alu_op                 datapath control strobes and selects
//   pc_en                          combined PC load enable
//   illegal                        sticky undecoded-opcode flag
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit EN_BNE        = 1'b1,
  parameter bit EN_JAL        = 1'b1,
  parameter bit EN_LOGIC_IMM  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       bne_q;
  logic       illegal_q;
  logic       rdy;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Later states see the opcode of the decoded instruction, not the live bus
      if (state_q == StDecode) begin
        op_q  <= opcode;
        bne_q <= (opcode == OpBne) && EN_BNE;
      end
      if (state_d == StHalt) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  state_d = rdy ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:    state_d = StMemAdr;
          OpRtype:       state_d = StExec;
          OpBeq:         state_d = StBranch;
          OpBne:         state_d = EN_BNE ? StBranch : StHalt;
          OpAddi:        state_d = StImmEx;
          OpAndi, OpOri: state_d = EN_LOGIC_IMM ? StImmEx : StHalt;
          OpJ:           state_d = StJump;
          OpJal:         state_d = EN_JAL ? StJal : StHalt;
          default:       state_d = StHalt;
        endcase
      end
      StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = rdy ? StMemWb : StMemRd;
      StMemWr:  state_d = rdy ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StImmEx:  state_d = StImmWb;
      StMemWb, StAluWb, StImmWb, StBranch, StJump, StJal: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PcAlu;
    reg_write  = 1'b0;
    reg_dst    = DstRt;
    mem_to_reg = WbAluOut;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcbReg;
    ext_zero   = 1'b0;
    alu_op     = AluAdd;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcbFour;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      StDecode: alu_src_b = SrcbBrOff;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcbImm;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = WbMdr;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = DstRd;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        branch    = 1'b1;
        pc_src    = PcAluOut;
      end
      StImmEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcbImm;
        case (op_q)
          OpAndi: begin
            alu_op   = AluAnd;
            ext_zero = 1'b1;
          end
          OpOri: begin
            alu_op   = AluOr;
            ext_zero = 1'b1;
          end
          default: alu_op = AluAdd;
        endcase
      end
      StImmWb: reg_write = 1'b1;
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcJump;
      end
      StJal: begin
        reg_write  = 1'b1;
        reg_dst    = DstRa;
        mem_to_reg = WbPc;
        pc_write   = 1'b1;
        pc_src     = PcJump;
      end
      default: ;
    endcase
  end

  // bne_q inverts the sense of zero so one branch state serves beq and bne
  assign pc_en   = pc_write | (branch & (zero ^ bne_q));
  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic [3:0] a_state, b_state;
  logic       a_iord, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_branch, a_pc_en;
  logic       b_iord, b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_branch, b_pc_en;
  logic [1:0] a_pc_src, a_reg_dst, a_mem_to_reg, a_alu_src_b;
  logic [1:0] b_pc_src, b_reg_dst, b_mem_to_reg, b_alu_src_b;
  logic       a_reg_write, a_alu_src_a, a_ext_zero, a_illegal;
  logic       b_reg_write, b_alu_src_a, b_ext_zero, b_illegal;
  logic [2:0] a_alu_op, b_alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt;

  logic [20:0] a_strobes;
  assign a_strobes = {a_iord, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_branch, a_pc_en,
                      a_pc_src, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b,
                      a_ext_zero, a_alu_op};

  always #5 clk = ~clk;

  // Default configuration
  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(a_state), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .branch(a_branch), .pc_en(a_pc_en),
    .pc_src(a_pc_src), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .ext_zero(a_ext_zero), .alu_op(a_alu_op), .illegal(a_illegal)
  );

  // Reduced configuration: optional opcodes illegal, no memory handshake
  mc_control_fsm #(
    .EN_BNE(1'b0), .EN_JAL(1'b0), .EN_LOGIC_IMM(1'b0), .MEM_HANDSHAKE(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(b_state), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .branch(b_branch), .pc_en(b_pc_en),
    .pc_src(b_pc_src), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .ext_zero(b_ext_zero), .alu_op(b_alu_op), .illegal(b_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle combinational outputs before checking
  task automatic step_chk(input string tag, input logic [31:0] exp_state);
    tick();
    #1;
    chk(tag, 32'(a_state), exp_state);
  endtask

  int lw_states [6] = '{1, 2, 3, 4, 5, 1};

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b100011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("reset_state", 32'(a_state), 0);
    chk("reset_outs", 32'(a_strobes), 0);
    chk("reset_illegal", 32'(a_illegal), 0);
    chk("reset_state_b", 32'(b_state), 0);
    rst_n = 1'b1;

    // lw, mem_ready tied high
    for (int i = 0; i < 6; i++) begin
      step_chk("lw_state", 32'(lw_states[i]));
      chk("lw_state_b", 32'(b_state), 32'(lw_states[i]));
      chk("lw_reg_write", 32'(a_reg_write), (lw_states[i] == 5) ? 1 : 0);
      if (lw_states[i] == 5) chk("lw_mem_to_reg", 32'(a_mem_to_reg), 1);
      if (lw_states[i] == 4) chk("lw_rd_iord", 32'({a_iord, a_mem_read}), 3);
      if (i == 0) chk("fetch_strobes", 32'({a_mem_read, a_ir_write, a_pc_write, a_alu_src_b}), 5'b11101);
    end

    // sw with three stall cycles in MEM_WR
    opcode = 6'b101011;
    step_chk("sw_decode", 2);
    step_chk("sw_memadr", 3);
    chk("sw_adr_srcs", 32'({a_alu_src_a, a_alu_src_b, a_alu_op}), 6'b110000);
    step_chk("sw_memwr", 6);
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("sw_wait_state", 32'(a_state), 6);
      if (a_mem_write === 1'b1) wr_cnt++;
      if (i < 3) tick();
    end
    chk("sw_write_cycles", 32'(wr_cnt), 4);
    step_chk("sw_return_fetch", 1);

    // bne with zero=0 takes the branch
    opcode = 6'b000101;
    step_chk("bne_decode", 2);
    step_chk("bne_branch", 9);
    chk("bne_ctrl", 32'({a_branch, a_pc_src, a_alu_op, a_alu_src_a}), 7'b1010011);
    chk("bne_pc_en", 32'(a_pc_en), 1);
    step_chk("bne_fetch", 1);

    // beq with zero=0 does not; zero=1 does
    opcode = 6'b000100;
    step_chk("beq_decode", 2);
    step_chk("beq_branch", 9);
    chk("beq_pc_en_z0", 32'(a_pc_en), 0);
    zero = 1'b1;
    #1;
    chk("beq_pc_en_z1", 32'(a_pc_en), 1);
    zero = 1'b0;
    step_chk("beq_fetch", 1);

    // ori; opcode bus changes during IMM_EX but the latched op governs
    opcode = 6'b001101;
    step_chk("ori_decode", 2);
    step_chk("ori_immex", 10);
    opcode = 6'b000000;
    #1;
    chk("ori_alu_op", 32'(a_alu_op), 3'b100);
    chk("ori_ext_zero", 32'(a_ext_zero), 1);
    chk("ori_srcs", 32'({a_alu_src_a, a_alu_src_b}), 3'b110);
    step_chk("ori_immwb", 11);
    chk("ori_reg_write", 32'({a_reg_write, a_reg_dst, a_mem_to_reg}), 5'b10000);
    step_chk("ori_fetch", 1);

    // jal: exactly one JAL cycle
    opcode = 6'b000011;
    step_chk("jal_decode", 2);
    step_chk("jal_state", 13);
    chk("jal_ctrl", 32'({a_reg_write, a_reg_dst, a_mem_to_reg, a_pc_write, a_pc_src}), 8'b11010110);
    step_chk("jal_fetch", 1);

    // j
    opcode = 6'b000010;
    step_chk("j_decode", 2);
    step_chk("j_state", 12);
    chk("j_ctrl", 32'({a_pc_write, a_pc_src, a_reg_write}), 4'b1100);
    step_chk("j_fetch", 1);

    // R-type
    opcode = 6'b000000;
    step_chk("r_decode", 2);
    step_chk("r_exec", 7);
    chk("r_exec_ctrl", 32'({a_alu_src_a, a_alu_op}), 4'b1010);
    step_chk("r_aluwb", 8);
    chk("r_wb_ctrl", 32'({a_reg_write, a_reg_dst}), 3'b101);
    step_chk("r_fetch", 1);

    // Undecoded opcode halts until reset
    opcode = 6'b111111;
    step_chk("ill_decode", 2);
    step_chk("ill_halt", 14);
    chk("ill_flag", 32'(a_illegal), 1);
    chk("ill_outs", 32'(a_strobes), 0);
    opcode = 6'b100011;
    step_chk("ill_stay1", 14);
    step_chk("ill_stay2", 14);
    chk("ill_sticky", 32'(a_illegal), 1);
    rst_n = 1'b0;
    step_chk("ill_reset", 0);
    chk("ill_cleared", 32'(a_illegal), 0);
    rst_n = 1'b1;

    // Reset asserted during a MEM_RD stall
    step_chk("rd_fetch", 1);
    step_chk("rd_decode", 2);
    step_chk("rd_memadr", 3);
    step_chk("rd_memrd", 4);
    mem_ready = 1'b0;
    step_chk("rd_stall", 4);
    chk("rd_stall_ctrl", 32'({a_iord, a_mem_read}), 3);
    rst_n = 1'b0;
    step_chk("rd_reset_state", 0);
    chk("rd_reset_outs", 32'(a_strobes), 0);
    chk("rd_reset_illegal", 32'(a_illegal), 0);

    // Reduced configuration: jal illegal, FETCH ignores mem_ready
    opcode = 6'b000011;
    rst_n  = 1'b1;
    step_chk("cfg_fetch", 1);
    chk("cfg_b_fetch", 32'(b_state), 1);
    chk("cfg_a_ir_write", 32'(a_ir_write), 0);
    chk("cfg_b_ir_write", 32'(b_ir_write), 1);
    step_chk("cfg_a_wait", 1);
    chk("cfg_b_decode", 32'(b_state), 2);
    tick();
    #1;
    chk("cfg_b_jal_halt", 32'(b_state), 14);
    chk("cfg_b_jal_illegal", 32'(b_illegal), 1);
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    opcode = 6'b000101;
    tick();
    tick();
    tick();
    #1;
    chk("cfg_b_bne_halt", 32'(b_state), 14);
    chk("cfg_b_bne_illegal", 32'(b_illegal), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter EN_BNE, default 1: 1 decodes bne (000101); 0 treats it as illegal.
REQ-002 Parameter EN_JAL, default 1: 1 decodes jal (000011); 0 treats it as illegal.
REQ-003 Parameter EN_LOGIC_IMM, default 1: 1 decodes andi (001100) and ori (001101); 0 treats them as illegal.
REQ-004 Parameter MEM_HANDSHAKE, default 1: 1 makes memory states wait for mem_ready; 0 ignores mem_ready (treated as 1).
REQ-005 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, reset: synchronous, active-low.
- opcode, in, 6, instruction[31:26] from the instruction register.
- zero, in, 1, ALU zero flag.
- mem_ready, in, 1, memory access complete this cycle.
- state, out, 4, current state code.
- iord, out, 1, 0 = instruction address, 1 = data address.
- mem_read, out, 1, read request.
- mem_write, out, 1, write request.
- ir_write, out, 1, load IR.
- pc_write, out, 1, unconditional PC load.
- branch, out, 1, conditional PC load.
- pc_en, out, 1, pc_write | (branch & (zero ^ bne_q)).
- pc_src, out, 2, 00 ALU, 01 ALUOut, 10 jump target.
- reg_write, out, 1, register file write.
- reg_dst, out, 2, 00 rt, 01 rd, 10 $31.
- mem_to_reg, out, 2, 00 ALUOut, 01 MDR, 10 PC.
- alu_src_a, out, 1, 0 PC, 1 A.
- alu_src_b, out, 2, 00 B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- ext_zero, out, 1, 1 = zero-extend imm, 0 = sign-extend imm.
- alu_op, out, 3, 000 add, 001 sub, 010 funct, 011 and, 100 or.
- illegal, out, 1, sticky flag for an undecoded opcode.

Function
REQ-006 The block SHALL be a registered-state FSM with outputs decoded from state, except that strobes qualified by mem_ready (see REQ-009) follow mem_ready in the same cycle.
REQ-007 State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC 7, ALU_WB 8, BRANCH 9, IMM_EX 10, IMM_WB 11, JUMP 12, JAL 13, HALT 14.
REQ-008 Transitions:
- IDLE -> FETCH.
- FETCH -> DECODE on mem_ready, else stay in FETCH.
- DECODE -> by opcode: lw/sw MEM_ADR; R-type (000000) EXEC; beq/bne BRANCH; addi/andi/ori IMM_EX; j JUMP; jal JAL; any other opcode HALT.
- MEM_ADR -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD -> MEM_WB on mem_ready.
- MEM_WR -> FETCH on mem_ready.
- EXEC -> ALU_WB; IMM_EX -> IMM_WB.
- MEM_WB, ALU_WB, IMM_WB, BRANCH, JUMP, JAL -> FETCH.
- HALT -> HALT.
REQ-009 Handshake-qualified strobes:
- FETCH: mem_read=1, alu_src_b=01, alu_op=add; ir_write and pc_write = mem_ready.
- MEM_RD: iord=1, mem_read=1.
- MEM_WR: iord=1; mem_write=1 held until mem_ready.
REQ-010 DECODE: alu_src_b=11, alu_op=add; capture bne_q = (opcode==000101) & EN_BNE.
REQ-011 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=add.
REQ-012 MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00.
REQ-013 EXEC: alu_src_a=1, alu_op=010. ALU_WB: reg_write=1, reg_dst=01.
REQ-014 BRANCH: alu_src_a=1, alu_op=sub, branch=1, pc_src=01; the PC loads only when pc_en=1.
REQ-015 IMM_EX: alu_src_a=1, alu_src_b=10; alu_op add/and/or for addi/andi/ori; ext_zero=1 for andi/ori. The opcode SHALL be latched in DECODE and used in IMM_EX.
REQ-016 IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
REQ-017 JUMP: pc_write=1, pc_src=10.
REQ-018 JAL (one cycle): reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10.
REQ-019 HALT: illegal=1 and all strobes 0; the block SHALL remain in HALT until reset.
REQ-020 Any output not listed for a state SHALL be 0.
REQ-021 With MEM_HANDSHAKE=1, the number of wait cycles in a memory state SHALL be unbounded, with no timeout.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force state=IDLE and clear bne_q, the latched opcode and illegal, regardless of the current state, including mid-access.
REQ-023 While in IDLE all outputs SHALL be 0; the first FETCH SHALL occur on the cycle after rst_n returns to 1.

Structure
REQ-024 State codes, the opcode constants and the alu_op / pc_src / reg_dst / mem_to_reg encodings SHALL live in the shared package mc_pkg, which is also used by the datapath and the ALU decoder.
REQ-025 The block SHALL be a single module with no sub-modules; next-state logic and output decode are separate always blocks.

Verification
REQ-026 Reset, then lw with mem_ready tied to 1: states 0,1,2,3,4,5,1; reg_write=1 only in MEM_WB with mem_to_reg=01.
REQ-027 sw with mem_ready low for 3 cycles in MEM_WR: mem_write=1 for 4 cycles, state returns to FETCH after mem_ready.
REQ-028 bne with zero=0: pc_en=1 in BRANCH; beq with zero=0: pc_en=0.
REQ-029 jal: exactly one JAL cycle with reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10; with EN_JAL=0, state goes to 14 and illegal=1.
REQ-030 ori: IMM_EX shows alu_op=100 and ext_zero=1; IMM_WB shows reg_write=1.
REQ-031 rst_n=0 asserted in MEM_RD during a stall: state=0 next edge, all outputs 0, illegal cleared.
